// File: rtl/dp_tap_ctrl.sv
// rtl/dp_tap_ctrl.sv - TAP controller sequencing the boundary scan register chain
module dp_tap_ctrl #(
    parameter int          ir_width = 4,
    parameter logic [31:0] idcode   = 32'h1000_0001
) (
    input  logic                iclk,
    input  logic                resetn,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                bsr_si,
    input  logic                bsr_so,
    output logic                mode,
    output logic                shift_dr,
    output logic                clk_dr,
    output logic                update_dr,
    output logic [ir_width-1:0] ir_out,
    output logic [3:0]          tap_state
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } state_t;

    localparam logic [ir_width-1:0] IR_EXTEST  = ir_width'(0);
    localparam logic [ir_width-1:0] IR_SAMPLE  = ir_width'(1);
    localparam logic [ir_width-1:0] IR_IDCODE  = ir_width'(2);
    localparam logic [ir_width-1:0] IR_CAPTURE = ir_width'(1);

    state_t              state_q;
    logic [ir_width-1:0] ir_shift_q, ir_shift_d;
    logic [ir_width-1:0] ir_q, ir_d;
    logic [31:0]         idcode_q, idcode_d;
    logic                bypass_q, bypass_d;

    logic sel_bsr;
    logic sel_id;

    // TAP state machine: walks the 16-state graph on each sampled tms
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= TLR;
        end else begin
            case (state_q)
                TLR:      state_q <= tms ? TLR      : RTI;
                RTI:      state_q <= tms ? SEL_DR   : RTI;
                SEL_DR:   state_q <= tms ? SEL_IR   : CAP_DR;
                CAP_DR:   state_q <= tms ? EX1_DR   : SHIFT_DR;
                SHIFT_DR: state_q <= tms ? EX1_DR   : SHIFT_DR;
                EX1_DR:   state_q <= tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_q <= tms ? EX2_DR   : PAUSE_DR;
                EX2_DR:   state_q <= tms ? UPD_DR   : SHIFT_DR;
                UPD_DR:   state_q <= tms ? SEL_DR   : RTI;
                SEL_IR:   state_q <= tms ? TLR      : CAP_IR;
                CAP_IR:   state_q <= tms ? EX1_IR   : SHIFT_IR;
                SHIFT_IR: state_q <= tms ? EX1_IR   : SHIFT_IR;
                EX1_IR:   state_q <= tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_q <= tms ? EX2_IR   : PAUSE_IR;
                EX2_IR:   state_q <= tms ? UPD_IR   : SHIFT_IR;
                UPD_IR:   state_q <= tms ? SEL_DR   : RTI;
                default:  state_q <= TLR;
            endcase
        end
    end

    // Undefined codes fall through to the bypass bit
    assign sel_bsr = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
    assign sel_id  = (ir_q == IR_IDCODE);

    // Data and instruction register next values; anything not named holds (covers PAUSE)
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        idcode_d   = idcode_q;
        bypass_d   = bypass_q;
        case (state_q)
            TLR:      ir_d = IR_IDCODE;
            CAP_IR:   ir_shift_d = IR_CAPTURE;
            SHIFT_IR: ir_shift_d = {tdi, ir_shift_q[ir_width-1:1]};
            UPD_IR:   ir_d = ir_shift_q;
            CAP_DR: begin
                bypass_d = 1'b0;
                if (sel_id) begin
                    idcode_d = idcode;
                end
            end
            SHIFT_DR: begin
                bypass_d = tdi;
                if (sel_id) begin
                    idcode_d = {tdi, idcode_q[31:1]};
                end
            end
            default: ;
        endcase
    end

    // Register bank; reset discards any partial IR shift and reselects IDCODE
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            ir_shift_q <= '0;
            ir_q       <= IR_IDCODE;
            idcode_q   <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_q       <= ir_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
        end
    end

    // Serial output mux keyed on state and the selected data register
    always_comb begin
        tdo = 1'b0;
        case (state_q)
            SHIFT_IR: tdo = ir_shift_q[0];
            SHIFT_DR: begin
                if (sel_bsr) begin
                    tdo = bsr_so;
                end else if (sel_id) begin
                    tdo = idcode_q[0];
                end else begin
                    tdo = bypass_q;
                end
            end
            default: ;
        endcase
    end

    assign tdo_en    = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
    assign bsr_si    = tdi;
    assign mode      = (ir_q == IR_EXTEST);
    assign shift_dr  = sel_bsr && (state_q == SHIFT_DR);
    assign clk_dr    = sel_bsr && ((state_q == CAP_DR) || (state_q == SHIFT_DR));
    assign update_dr = sel_bsr && (state_q == UPD_DR);
    assign ir_out    = ir_q;
    assign tap_state = state_q;

endmodule
